// File: rtl/soc_ctrl_counter_pkg.sv
// Shared types and the next-count helper for the multi-channel SoC counter.
// Arithmetic is done at a fixed 32-bit word width; channels truncate the result.
package soc_ctrl_counter_pkg;

  typedef enum logic {CTR_WRAP, CTR_SAT} ctr_mode_e;
  typedef enum logic {CTR_UP, CTR_DOWN} ctr_dir_e;

  localparam int unsigned CTR_MAX_W = 32;

  typedef logic [CTR_MAX_W-1:0] ctr_word_t;
  typedef logic [CTR_MAX_W:0]   ctr_wide_t;

  // Event sits in the LSB so a caller can keep the low WIDTH+1 bits as {count, event}.
  typedef struct packed {
    ctr_word_t count;
    logic      evt;
  } ctr_next_t;

  function automatic ctr_next_t ctr_next(input ctr_word_t count,
                                         input ctr_word_t step,
                                         input ctr_word_t max,
                                         input ctr_mode_e mode,
                                         input ctr_dir_e  dir);
    ctr_next_t r;
    ctr_wide_t s;
    ctr_wide_t lim;
    ctr_wide_t acc;
    r   = '0;
    s   = (step < max) ? {1'b0, step} : {1'b0, max};
    lim = {1'b0, max} + ctr_wide_t'(1);
    acc = '0;
    if (max == '0) begin
      // Degenerate range: every count event lands on zero; only wrap mode reports it.
      r.count = '0;
      r.evt   = (mode == CTR_WRAP);
    end else if (dir == CTR_UP) begin
      acc = {1'b0, count} + s;
      if (acc <= {1'b0, max}) begin
        r.count = acc[CTR_MAX_W-1:0];
      end else if (mode == CTR_WRAP) begin
        acc     = acc - lim;
        r.count = acc[CTR_MAX_W-1:0];
        r.evt   = 1'b1;
      end else begin
        r.count = max;
        r.evt   = (count < max);
      end
    end else begin
      if ({1'b0, count} >= s) begin
        acc     = {1'b0, count} - s;
        r.count = acc[CTR_MAX_W-1:0];
      end else if (mode == CTR_WRAP) begin
        acc     = {1'b0, count} - s + lim;
        r.count = acc[CTR_MAX_W-1:0];
        r.evt   = 1'b1;
      end else begin
        r.count = '0;
        r.evt   = (count != '0);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/soc_ctrl_counter_ch.sv
// One counter channel: load/hold/count decision plus the count and event registers.
module soc_ctrl_counter_ch
  import soc_ctrl_counter_pkg::*;
#(
  parameter int unsigned       WIDTH       = 16,
  parameter int unsigned       STEP_W      = 4,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              en_i,
  input  logic              up_i,
  input  logic              down_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic [WIDTH-1:0]  max_i,
  input  ctr_mode_e         mode_i,
  input  logic              load_i,
  input  logic [WIDTH-1:0]  load_val_i,
  output logic [WIDTH-1:0]  count_o,
  output logic              event_o,
  output logic              at_max_o,
  output logic              at_zero_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             event_q, event_d;

  always_comb begin
    count_d = count_q;
    event_d = 1'b0;
    if (load_i) begin
      count_d = (load_val_i < max_i) ? load_val_i : max_i;
    end else if (en_i && (up_i != down_i) && (step_i != '0)) begin
      {count_d, event_d} = (WIDTH+1)'(ctr_next(ctr_word_t'(count_q),
                                               ctr_word_t'(step_i),
                                               ctr_word_t'(max_i),
                                               mode_i,
                                               up_i ? CTR_UP : CTR_DOWN));
    end
  end

  // Reset value is applied verbatim, even if it exceeds the channel's max.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      count_q <= RESET_VALUE;
      event_q <= 1'b0;
    end else begin
      count_q <= count_d;
      event_q <= event_d;
    end
  end

  assign count_o   = count_q;
  assign event_o   = event_q;
  assign at_max_o  = (count_q >= max_i);
  assign at_zero_o = (count_q == '0);

endmodule

// File: rtl/soc_ctrl_multi_counter.sv
// NUM_CH independent up/down counters with runtime limit, step, wrap/saturate and load.
module soc_ctrl_multi_counter
  import soc_ctrl_counter_pkg::*;
#(
  parameter int unsigned      NUM_CH      = 4,
  parameter int unsigned      WIDTH       = 16,
  parameter int unsigned      STEP_W      = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              en_i       [NUM_CH],
  input  logic              up_i       [NUM_CH],
  input  logic              down_i     [NUM_CH],
  input  logic [STEP_W-1:0] step_i     [NUM_CH],
  input  logic [WIDTH-1:0]  max_i      [NUM_CH],
  input  ctr_mode_e         mode_i     [NUM_CH],
  input  logic              load_i     [NUM_CH],
  input  logic [WIDTH-1:0]  load_val_i [NUM_CH],
  output logic [WIDTH-1:0]  count_o    [NUM_CH],
  output logic              event_o    [NUM_CH],
  output logic              at_max_o   [NUM_CH],
  output logic              at_zero_o  [NUM_CH]
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    soc_ctrl_counter_ch #(
      .WIDTH      (WIDTH),
      .STEP_W     (STEP_W),
      .RESET_VALUE(RESET_VALUE)
    ) u_ch (
      .clk_i     (clk_i),
      .arst_i    (arst_i),
      .en_i      (en_i[g]),
      .up_i      (up_i[g]),
      .down_i    (down_i[g]),
      .step_i    (step_i[g]),
      .max_i     (max_i[g]),
      .mode_i    (mode_i[g]),
      .load_i    (load_i[g]),
      .load_val_i(load_val_i[g]),
      .count_o   (count_o[g]),
      .event_o   (event_o[g]),
      .at_max_o  (at_max_o[g]),
      .at_zero_o (at_zero_o[g])
    );
  end

endmodule

// File: tb/tb_soc_ctrl_multi_counter.sv
// Directed bench for soc_ctrl_multi_counter (4 channels, 8-bit, reset value 5).
module tb_soc_ctrl_multi_counter;
  import soc_ctrl_counter_pkg::*;

  localparam int unsigned NCH = 4;
  localparam int unsigned W   = 8;
  localparam int unsigned SW  = 4;

  logic          clk;
  logic          arst;
  logic          en       [NCH];
  logic          up       [NCH];
  logic          down     [NCH];
  logic [SW-1:0] step     [NCH];
  logic [W-1:0]  max_v    [NCH];
  ctr_mode_e     mode     [NCH];
  logic          load     [NCH];
  logic [W-1:0]  load_val [NCH];
  logic [W-1:0]  count    [NCH];
  logic          evt      [NCH];
  logic          at_max   [NCH];
  logic          at_zero  [NCH];

  int n_checks = 0;
  int n_fail   = 0;

  soc_ctrl_multi_counter #(
    .NUM_CH     (NCH),
    .WIDTH      (W),
    .STEP_W     (SW),
    .RESET_VALUE(8'd5)
  ) dut (
    .clk_i     (clk),
    .arst_i    (arst),
    .en_i      (en),
    .up_i      (up),
    .down_i    (down),
    .step_i    (step),
    .max_i     (max_v),
    .mode_i    (mode),
    .load_i    (load),
    .load_val_i(load_val),
    .count_o   (count),
    .event_o   (evt),
    .at_max_o  (at_max),
    .at_zero_o (at_zero)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic e, input logic u, input logic d,
                        input logic [SW-1:0] s, input logic [W-1:0] mx, input ctr_mode_e m,
                        input logic ld, input logic [W-1:0] lv);
    en[ch] = e; up[ch] = u; down[ch] = d; step[ch] = s;
    max_v[ch] = mx; mode[ch] = m; load[ch] = ld; load_val[ch] = lv;
  endtask

  task automatic idle_ch(input int ch);
    set_ch(ch, 1'b0, 1'b0, 1'b0, 4'd0, max_v[ch], mode[ch], 1'b0, 8'd0);
  endtask

  initial begin
    arst = 1'b1;
    for (int i = 0; i < NCH; i++) set_ch(i, 1'b0, 1'b0, 1'b0, 4'd0, 8'd200, CTR_WRAP, 1'b0, 8'd0);

    // reset and hold
    #12;
    for (int i = 0; i < NCH; i++) begin
      check($sformatf("rst_count%0d", i), 32'(count[i]), 32'd5);
      check($sformatf("rst_event%0d", i), 32'(evt[i]), 32'd0);
    end
    check("rst_at_max0", 32'(at_max[0]), 32'd0);
    check("rst_at_zero0", 32'(at_zero[0]), 32'd0);
    tick();
    arst = 1'b0;
    tick();
    tick();
    for (int i = 0; i < NCH; i++) check($sformatf("hold_count%0d", i), 32'(count[i]), 32'd5);

    // ch0 wrap up: max 9, step 3, from 8
    set_ch(0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd9, CTR_WRAP, 1'b1, 8'd8);
    tick();
    check("wrap_load", 32'(count[0]), 32'd8);
    set_ch(0, 1'b1, 1'b1, 1'b0, 4'd3, 8'd9, CTR_WRAP, 1'b0, 8'd0);
    tick();
    check("wrap_count", 32'(count[0]), 32'd1);
    check("wrap_event", 32'(evt[0]), 32'd1);
    tick();
    check("wrap_next_count", 32'(count[0]), 32'd4);
    check("wrap_next_event", 32'(evt[0]), 32'd0);
    idle_ch(0);

    // ch1 sat down: max 100, step 4, from 2
    set_ch(1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd100, CTR_SAT, 1'b1, 8'd2);
    tick();
    check("sat_load", 32'(count[1]), 32'd2);
    set_ch(1, 1'b1, 1'b0, 1'b1, 4'd4, 8'd100, CTR_SAT, 1'b0, 8'd0);
    tick();
    check("sat_count", 32'(count[1]), 32'd0);
    check("sat_event", 32'(evt[1]), 32'd1);
    check("sat_at_zero", 32'(at_zero[1]), 32'd1);
    tick();
    check("sat_again_count", 32'(count[1]), 32'd0);
    check("sat_again_event", 32'(evt[1]), 32'd0);
    idle_ch(1);

    // ch2 priority: load beats disabled up, clamped to max
    set_ch(2, 1'b0, 1'b1, 1'b0, 4'd1, 8'd20, CTR_SAT, 1'b1, 8'd50);
    tick();
    check("prio_load_clamp", 32'(count[2]), 32'd20);
    check("prio_at_max", 32'(at_max[2]), 32'd1);
    check("prio_event", 32'(evt[2]), 32'd0);
    set_ch(2, 1'b1, 1'b1, 1'b1, 4'd1, 8'd20, CTR_SAT, 1'b0, 8'd0);
    tick();
    check("prio_updown_hold", 32'(count[2]), 32'd20);
    idle_ch(2);

    // ch3 full range wrap: max 255, step 15, from 250
    set_ch(3, 1'b0, 1'b0, 1'b0, 4'd0, 8'd255, CTR_WRAP, 1'b1, 8'd250);
    tick();
    check("full_load", 32'(count[3]), 32'd250);
    set_ch(3, 1'b1, 1'b1, 1'b0, 4'd15, 8'd255, CTR_WRAP, 1'b0, 8'd0);
    tick();
    check("full_count", 32'(count[3]), 32'd9);
    check("full_event", 32'(evt[3]), 32'd1);
    for (int i = 0; i < 3; i++) check($sformatf("iso_ch%0d_event", i), 32'(evt[i]), 32'd0);
    check("iso_ch0_count", 32'(count[0]), 32'd4);

    // all four channels at once, different modes and directions
    set_ch(0, 1'b1, 1'b1, 1'b0, 4'd3, 8'd9,   CTR_WRAP, 1'b0, 8'd0);
    set_ch(1, 1'b1, 1'b1, 1'b0, 4'd4, 8'd100, CTR_SAT,  1'b0, 8'd0);
    set_ch(2, 1'b1, 1'b0, 1'b1, 4'd5, 8'd20,  CTR_SAT,  1'b0, 8'd0);
    set_ch(3, 1'b1, 1'b0, 1'b1, 4'd15, 8'd255, CTR_WRAP, 1'b0, 8'd0);
    tick();
    check("mix1_c0", 32'(count[0]), 32'd7);
    check("mix1_c1", 32'(count[1]), 32'd4);
    check("mix1_c2", 32'(count[2]), 32'd15);
    check("mix1_c3", 32'(count[3]), 32'd250);
    check("mix1_e0", 32'(evt[0]), 32'd0);
    check("mix1_e3", 32'(evt[3]), 32'd1);
    tick();
    check("mix2_c0", 32'(count[0]), 32'd0);
    check("mix2_c1", 32'(count[1]), 32'd8);
    check("mix2_c2", 32'(count[2]), 32'd10);
    check("mix2_c3", 32'(count[3]), 32'd235);
    check("mix2_e0", 32'(evt[0]), 32'd1);
    check("mix2_e3", 32'(evt[3]), 32'd0);

    // max=0 and max lowered below count
    set_ch(0, 1'b1, 1'b1, 1'b0, 4'd1, 8'd0,   CTR_WRAP, 1'b0, 8'd0);
    set_ch(1, 1'b1, 1'b1, 1'b0, 4'd1, 8'd0,   CTR_SAT,  1'b0, 8'd0);
    set_ch(2, 1'b1, 1'b1, 1'b0, 4'd2, 8'd6,   CTR_SAT,  1'b0, 8'd0);
    set_ch(3, 1'b1, 1'b1, 1'b0, 4'd3, 8'd100, CTR_WRAP, 1'b0, 8'd0);
    tick();
    check("max0_wrap_count", 32'(count[0]), 32'd0);
    check("max0_wrap_event", 32'(evt[0]), 32'd1);
    check("max0_sat_count", 32'(count[1]), 32'd0);
    check("max0_sat_event", 32'(evt[1]), 32'd0);
    check("lower_sat_count", 32'(count[2]), 32'd6);
    check("lower_sat_event", 32'(evt[2]), 32'd0);
    check("lower_wrap_count", 32'(count[3]), 32'd137);
    check("lower_wrap_event", 32'(evt[3]), 32'd1);

    // async reset mid-count
    set_ch(0, 1'b1, 1'b1, 1'b0, 4'd1, 8'd200, CTR_WRAP, 1'b0, 8'd0);
    tick();
    check("pre_rst_count", 32'(count[0]), 32'd1);
    #3 arst = 1'b1;
    #1;
    for (int i = 0; i < NCH; i++) check($sformatf("arst_count%0d", i), 32'(count[i]), 32'd5);
    check("arst_event3", 32'(evt[3]), 32'd0);
    tick();
    check("arst_hold_count0", 32'(count[0]), 32'd5);
    check("arst_hold_event0", 32'(evt[0]), 32'd0);
    arst = 1'b0;
    tick();
    check("post_rst_count0", 32'(count[0]), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/soc_ctrl_multi_counter.md
# soc_ctrl_multi_counter

Multi-channel, parametrised up/down counter for the SoC control block. It succeeds the single-channel fixed-step counter. Each of `NUM_CH` independent channels adds:
- a runtime limit and step size,
- a per-channel wrap or saturate mode,
- synchronous load,
- a registered terminal-event pulse.

Timer, watchdog and event-tally logic in `soc_ctrl` instantiate it in place of multiple scalar counters.

## Interface
Parameters:
- `NUM_CH`, 4, number of independent channels (≥1)
- `WIDTH`, 16, counter width per channel (2..32)
- `STEP_W`, 4, width of the per-channel step input (1..`WIDTH`)
- `RESET_VALUE`, '0, `WIDTH`-bit value loaded into every channel on reset

Ports (arrays are unpacked `[NUM_CH]`). One clock; reset is asynchronous and active-high.
- `clk_i`  in  1  clock
- `arst_i`  in  1  asynchronous active-high reset
- `en_i`  in  [NUM_CH]x1  channel count enable
- `up_i`  in  [NUM_CH]x1  increment request
- `down_i`  in  [NUM_CH]x1  decrement request
- `step_i`  in  [NUM_CH]x`STEP_W`  amount per count event
- `max_i`  in  [NUM_CH]x`WIDTH`  runtime upper limit (inclusive)
- `mode_i`  in  [NUM_CH]x`ctr_mode_e`  `CTR_WRAP` or `CTR_SAT`
- `load_i`  in  [NUM_CH]x1  synchronous load strobe
- `load_val_i`  in  [NUM_CH]x`WIDTH`  load value
- `count_o`  out  [NUM_CH]x`WIDTH`  current count (registered)
- `event_o`  out  [NUM_CH]x1  one-cycle pulse on wrap or saturation hit (registered)
- `at_max_o`  out  [NUM_CH]x1  combinational: `count_o >= max_i`
- `at_zero_o`  out  [NUM_CH]x1  combinational: `count_o == 0`

## Operation
Channels are fully independent. Per channel, each rising edge applies the first matching rule below:
1. `load_i`=1: count ← min(`load_val_i`, `max_i`), event ← 0. `en_i` is ignored.
2. `en_i`=0, or `up_i`==`down_i`, or `step_i`=0: count holds, event ← 0.
3. Up (`up_i`=1, `down_i`=0). The sum is computed in `WIDTH+1` bits; s = min(step, `max_i`).
   - If count + s ≤ max: count ← count + s, event ← 0.
   - Otherwise, in WRAP mode: count ← count + s − (max+1), event ← 1.
   - Otherwise, in SAT mode: count ← max. Event ← 1 only if count was < max before the edge.
4. Down (`down_i`=1, `up_i`=0), with the same s.
   - If count ≥ s: count ← count − s, event ← 0.
   - Otherwise, in WRAP mode: count ← count − s + max + 1, event ← 1.
   - Otherwise, in SAT mode: count ← 0. Event ← 1 only if count was > 0 before the edge.

Boundary rules:
- `max_i`=0: every up or down event keeps count at 0. WRAP mode pulses event every event; SAT mode never pulses.
- `max_i` lowered below the current count: the next up event is an overflow (WRAP → count + s − (max+1) truncated to `WIDTH`; SAT → max). Down events proceed normally.
- `mode_i` and `max_i` are sampled on the same edge as the count event; changing them mid-count needs no handshake.
- `max_i` = 2^`WIDTH`−1: the wrap arithmetic must not lose the carry; an up-step from max gives step−1.

## Timing
- Reset (`arst_i`=1, asynchronous): `count_o` = `RESET_VALUE` (not clamped), `event_o` = 0, all channels.
- Reset release is synchronous to the design.
- Latency: one cycle from input to `count_o`/`event_o`. `event_o` is asserted in the same cycle the wrapped or saturated count appears.
- `at_max_o`/`at_zero_o` follow `count_o` combinationally (zero latency).
- Reset asserted mid-operation aborts any pending update. No state survives reset.

## Structure
- Package `soc_ctrl_counter_pkg`:
  - `typedef enum logic {CTR_WRAP, CTR_SAT} ctr_mode_e`
  - helper function `ctr_next` computing next count and event from (count, step, max, mode, dir)
- Sub-module `soc_ctrl_counter_ch`: one channel (registers plus next-state logic).
- Top level: a generate loop instantiating `NUM_CH` copies plus the array port mapping.

## Test plan
- Reset/hold: hold `arst_i` with `RESET_VALUE`=5 → all `count_o`=5, `event_o`=0. Release with `en_i`=0 → counts stay 5.
- WRAP up: `max_i`=9, step=3, count=8, up → count 1, `event_o`=1 for one cycle. Next up → count 4, event 0.
- SAT down: `max_i`=100, step=4, count=2, down → count 0, event 1. Second down → count 0, event 0.
- Priority: `load_i`=1, `load_val_i`=50, `max_i`=20, `up_i`=1, `en_i`=0 → count 20. `up_i`=`down_i`=1 → count holds.
- Full range: `WIDTH`=8, `max_i`=255, WRAP, step=15, count=250, up → count 9, event 1. Channels 0..3 driven with different modes concurrently show no cross-talk.
- Async reset mid-count: assert `arst_i` between edges while channel counts → `count_o`=`RESET_VALUE` immediately, no `event_o` pulse.
